// File: rtl/load_monitor_if.sv
// Sensor, acknowledge and status bundle for load_monitor.
// The slave modport is the monitor; the master modport is the sensor/operator side.
interface load_monitor_if #(
  parameter int CNT_W = 4
);
  logic             board;
  logic             alight;
  logic             ack;
  logic [CNT_W-1:0] occupancy;
  logic             warn;
  logic             overload;
  logic             underflow;

  modport master (
    output board, alight, ack,
    input  occupancy, warn, overload, underflow
  );

  modport slave (
    input  board, alight, ack,
    output occupancy, warn, overload, underflow
  );
endinterface

// File: rtl/load_monitor.sv
// Occupancy counter with warn/overload supervision, fed by two asynchronous edge sensors.
// Optional input debounce filter is compiled in with `define LOAD_MONITOR_DEBOUNCE_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_NORMAL   | occupancy below WARN_LEVEL
// S_WARN     | WARN_LEVEL <= occupancy <= CAPACITY
// S_OVERLOAD | occupancy exceeded CAPACITY; held until ack with occupancy back in range
module load_monitor #(
  parameter int CNT_W      = 4,
  parameter int CAPACITY   = 6,
  parameter int WARN_LEVEL = 5,
  parameter int DEB_CYC    = 4
) (
  input  logic           clk,
  input  logic           reset,
  load_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    S_NORMAL   = 2'd0,
    S_WARN     = 2'd1,
    S_OVERLOAD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] OCC_MAX = '1;
  localparam logic [CNT_W-1:0] CAP_V   = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] WARN_V  = CNT_W'(WARN_LEVEL);

  // bit 0 = board, bit 1 = alight
  logic [1:0]       sync1, sync2, lvl, lvl_d, armed, ev;
  logic [1:0]       fill_cnt;
  logic             filled;
  logic             inc, dec, unf_set;
  logic [CNT_W-1:0] occ_q, occ_nxt;
  state_t           state_q, state_nxt;
  logic             warn_q, ovl_q, unf_q;

  assign filled = (fill_cnt == 2'd2);

  // An input only becomes armed once a genuine low has been sampled after reset,
  // so a sensor held high across reset release never counts as an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      lvl_d    <= '0;
      armed    <= '0;
      fill_cnt <= '0;
    end else begin
      sync1    <= {bus.alight, bus.board};
      sync2    <= sync1;
      lvl_d    <= lvl;
      armed    <= armed | ({2{filled}} & ~sync2);
      fill_cnt <= filled ? fill_cnt : fill_cnt + 2'd1;
    end
  end

`ifdef LOAD_MONITOR_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYC + 1);

  logic [DW-1:0] deb_cnt [2];
  logic [1:0]    filt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt       <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYC - 1)) begin
          filt[i]    <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign lvl = filt;
`else
  logic unused_deb_cyc;
  assign unused_deb_cyc = ^DEB_CYC;
  assign lvl            = sync2;
`endif

  assign ev  = lvl & ~lvl_d & armed;
  assign inc = ev[0] & ~ev[1];
  assign dec = ev[1] & ~ev[0];

  always_comb begin
    occ_nxt = occ_q;
    unf_set = 1'b0;
    if (inc) begin
      if (occ_q != OCC_MAX) occ_nxt = occ_q + 1'b1;
    end else if (dec) begin
      if (occ_q == '0) unf_set = 1'b1;
      else             occ_nxt = occ_q - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_OVERLOAD: begin
        if (bus.ack && (occ_nxt <= CAP_V))
          state_nxt = (occ_nxt >= WARN_V) ? S_WARN : S_NORMAL;
      end
      default: begin
        if (occ_nxt > CAP_V)        state_nxt = S_OVERLOAD;
        else if (occ_nxt >= WARN_V) state_nxt = S_WARN;
        else                        state_nxt = S_NORMAL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q   <= '0;
      state_q <= S_NORMAL;
      warn_q  <= 1'b0;
      ovl_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      occ_q   <= occ_nxt;
      state_q <= state_nxt;
      warn_q  <= (state_nxt == S_WARN);
      ovl_q   <= (state_nxt == S_OVERLOAD);
      unf_q   <= unf_q | unf_set;
    end
  end

  assign bus.occupancy = occ_q;
  assign bus.warn      = warn_q;
  assign bus.overload  = ovl_q;
  assign bus.underflow = unf_q;

endmodule

// File: tb/tb_load_monitor.sv
// Scoreboard bench for load_monitor: stimulus pushes expected snapshots, a negedge monitor pops and compares.
module tb_load_monitor;
  localparam int CNT_W = 4;
  localparam int CAP   = 6;
  localparam int WARN  = 5;
  localparam int DEB   = 4;
  localparam int OMAX  = 15;
`ifdef LOAD_MONITOR_DEBOUNCE_EN
  localparam int LAT    = 3 + DEB;
  localparam int HI_MIN = DEB + 2;
  localparam int LO_MIN = DEB + 3;
`else
  localparam int LAT    = 3;
  localparam int HI_MIN = 2;
  localparam int LO_MIN = 4;
`endif

  logic clk = 1'b0;
  logic reset;

  load_monitor_if #(.CNT_W(CNT_W)) bus ();

  load_monitor #(
    .CNT_W(CNT_W), .CAPACITY(CAP), .WARN_LEVEL(WARN), .DEB_CYC(DEB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    int occ;
    int warn;
    int ovl;
    int unf;
  } exp_t;

  exp_t  q[$];
  exp_t  mon_e;
  int    n_vec = 0;
  int    n_bad = 0;
  int    m_occ = 0;
  bit    m_ovl = 0;
  bit    m_unf = 0;
  string phase = "reset";

  function automatic void chk(string nm, int act, int expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s [%s] cyc %0d: got %0d expected %0d", nm, phase, cyc, act, expv);
    end
  endfunction

  // Reference model: the snapshot the outputs should show at cycle 'due'.
  function automatic void push(int due);
    exp_t e;
    e.due  = due;
    e.occ  = m_occ;
    e.ovl  = m_ovl ? 1 : 0;
    e.warn = (!m_ovl && m_occ >= WARN) ? 1 : 0;
    e.unf  = m_unf ? 1 : 0;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      mon_e = q.pop_front();
      if (mon_e.due < cyc) begin
        chk("missed slot", cyc, mon_e.due);
      end else begin
        chk("occupancy", int'(bus.occupancy), mon_e.occ);
        chk("warn",      int'(bus.warn),      mon_e.warn);
        chk("overload",  int'(bus.overload),  mon_e.ovl);
        chk("underflow", int'(bus.underflow), mon_e.unf);
      end
    end
  end

  task automatic ev(input bit b, input bit a, input int hi, input int lo);
    int c0 = cyc;
    push(c0 + LAT - 1);
    if (b && !a) begin
      m_occ = (m_occ < OMAX) ? m_occ + 1 : OMAX;
    end else if (a && !b) begin
      if (m_occ == 0) m_unf = 1;
      else            m_occ = m_occ - 1;
    end
    if (m_occ > CAP) m_ovl = 1;
    push(c0 + LAT);
    bus.board  = b;
    bus.alight = a;
    repeat (hi) @(negedge clk);
    bus.board  = 1'b0;
    bus.alight = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic do_ack();
    int c0 = cyc;
    push(c0);
    if (m_ovl && m_occ <= CAP) m_ovl = 0;
    push(c0 + 1);
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      chk("drain timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic check_zero(string nm);
    chk({nm, " occupancy"}, int'(bus.occupancy), 0);
    chk({nm, " warn"},      int'(bus.warn),      0);
    chk({nm, " overload"},  int'(bus.overload),  0);
    chk({nm, " underflow"}, int'(bus.underflow), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_zero("async reset");
    m_occ = 0;
    m_ovl = 0;
    m_unf = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, hi, lo;
    reset      = 1'b1;
    bus.board  = 1'b0;
    bus.alight = 1'b0;
    bus.ack    = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset state");
    reset = 1'b0;
    repeat (4) @(negedge clk);

    phase = "five boards";
    repeat (5) ev(1, 0, HI_MIN, LO_MIN);

    phase = "overload";
    repeat (2) ev(1, 0, HI_MIN, LO_MIN);
    do_ack();
    ev(0, 1, HI_MIN, LO_MIN);
    do_ack();

    phase = "simultaneous";
    repeat (3) ev(0, 1, HI_MIN, LO_MIN);
    ev(1, 1, HI_MIN, LO_MIN);

    phase = "underflow";
    repeat (4) ev(0, 1, HI_MIN, LO_MIN);
    ev(1, 0, HI_MIN, LO_MIN);
    drain();
    do_reset();

    phase = "saturate";
    repeat (16) ev(1, 0, HI_MIN, LO_MIN);
    drain();

    phase = "reset mid-pulse";
    bus.board = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero("mid-pulse reset");
    m_occ = 0;
    m_ovl = 0;
    m_unf = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (LAT + 8) @(negedge clk);
    check_zero("held across release");
    bus.board = 1'b0;
    repeat (LO_MIN) @(negedge clk);
    ev(1, 0, HI_MIN, LO_MIN);

`ifdef LOAD_MONITOR_DEBOUNCE_EN
    phase = "short pulse";
    push(cyc + LAT + 2);
    bus.board = 1'b1;
    repeat (DEB - 1) @(negedge clk);
    bus.board = 1'b0;
    repeat (LO_MIN + 4) @(negedge clk);
    ev(1, 0, DEB + 2, LO_MIN);
`endif

    phase = "random";
    repeat (90) begin
      r  = int'($urandom_range(0, 9));
      hi = HI_MIN + int'($urandom_range(0, 2));
      lo = LO_MIN + int'($urandom_range(0, 2));
      case (r)
        0, 1, 2, 3: ev(1, 0, hi, lo);
        4, 5, 6:    ev(0, 1, hi, lo);
        7:          ev(1, 1, hi, lo);
        8:          do_ack();
        default:    ev(0, 0, hi, lo);
      endcase
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
